vpu_cmd_issue_gate: RTL and testbench
=====================================

Name: vpu_cmd_issue_gate

Overview:
Command-issue gate sitting directly upstream of the VPU timing counters. Accepts one decoded command at a time and selects which timing counter guards it. Holds the command until that counter reports zero, then issues it downstream. On issue, reloads the same counter with the command's post-issue delay. Drives NUM_CNTR external timing counters: reset command/value out, is-zero flag in.

Parameters:
CNTR_WIDTH, 4, width of each timing counter reload value
NUM_CNTR, 4, number of timing counters driven/observed
CMD_WIDTH, 8, opaque command payload width
SEL_WIDTH, $clog2(NUM_CNTR) (min 1), counter-select width

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
cmd_valid_i  input  1  upstream command valid
cmd_ready_o  output  1  gate can accept a command
cmd_i  input  CMD_WIDTH  command payload
cmd_sel_i  input  SEL_WIDTH  index of guarding timing counter
cmd_delay_i  input  CNTR_WIDTH  reload value applied to that counter on issue
issue_valid_o  output  1  command presented downstream
issue_ready_i  input  1  downstream accepts
issue_cmd_o  output  CMD_WIDTH  latched payload
cntr_reset_cmd_o  output  NUM_CNTR  per-counter reload strobe
cntr_reset_value_o  output  NUM_CNTR*CNTR_WIDTH  per-counter reload value, lane i at [i*CNTR_WIDTH +: CNTR_WIDTH]
cntr_is_zero_i  input  NUM_CNTR  per-counter registered is-zero flag

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset: state IDLE; cmd_ready_o=1; issue_valid_o=0; issue_cmd_o=0; cntr_reset_cmd_o=0; cntr_reset_value_o=0; latched sel/delay=0.
- FSM states: IDLE, WAIT, ISSUE.
  - IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o, latch cmd_i, cmd_sel_i, cmd_delay_i -> WAIT.
  - WAIT: cmd_ready_o=0. If cntr_is_zero_i[sel]=1 -> ISSUE next cycle; otherwise stay.
  - ISSUE: issue_valid_o=1; issue_cmd_o=latched payload, stable until handshake. On issue_valid_o&issue_ready_i -> IDLE.
- Reload strobe: cntr_reset_cmd_o[sel] = (state==ISSUE)&issue_ready_i. Combinational, same cycle as the issue handshake; all other lanes 0.
- Reload value: cntr_reset_value_o lane sel = latched delay while in ISSUE; all other lanes, and all lanes in other states, = 0.
- Counter timing: the counter loads at the edge that ends the handshake; its is_zero drops the following cycle.
- Minimum accept-to-issue latency: 2 cycles (accept T, WAIT T+1 sees zero, issue_valid_o at T+2). Back-to-back accepts: 1 per 3 cycles minimum.
- Delay 0: strobe still pulses with value 0; counter stays zero; the next command on the same counter is not stalled.
- Same-counter follow-up: the next command reaches WAIT no earlier than 1 cycle after the reload, so it observes the updated is_zero. No hazard.
- sel >= NUM_CNTR (non-power-of-two NUM_CNTR): treated as unguarded. WAIT -> ISSUE immediately; no reload strobe on any lane.
- issue_ready_i held low: remain in ISSUE indefinitely; payload and valid are held, no strobe.
- Reset mid-operation: any state -> IDLE asynchronously; the latched command is dropped, no strobe is emitted.
- cntr_is_zero_i lanes other than sel are ignored.

Optional Feature:
Macro VPU_ISSUE_STALL_CNT_EN.
- Defined: adds output stall_cnt_o [15:0], a saturating counter of cycles spent in WAIT with cntr_is_zero_i[sel]=0.
  - Cleared by rst; holds at 16'hFFFF.
  - Not cleared between commands.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Counter 2 already zero, cmd sel=2 delay=5 accepted at T with issue_ready_i=1 -> issue_valid_o at T+2; cntr_reset_cmd_o=4'b0100 with lane2 value 5 at T+2; IDLE at T+3.
- Counter 1 is_zero low for 7 cycles after cmd sel=1 -> issue_valid_o stays 0; rises the cycle after is_zero goes high. With the macro enabled, stall_cnt_o=7.
- Two cmds to counter 0, delays 3 then 0, attached to a real timing counter, ready=1 -> second issue at least 3+1 cycles after the first. Delay-0 issue pulses the strobe with value 0.
- ISSUE with issue_ready_i low 4 cycles -> issue_cmd_o stable; no strobe; cmd_ready_o=0. Strobe occurs only in the handshake cycle.
- Assert rst during WAIT and during ISSUE -> all outputs return to reset values immediately, with no strobe. First command after reset issues normally.
- With the macro enabled, hold WAIT stalled more than 65535 cycles -> stall_cnt_o saturates at 16'hFFFF.

Source files
------------

// File: rtl/vpu_cmd_issue_gate.sv
// vpu_cmd_issue_gate: holds one decoded command until its guarding timing counter reads zero,
// issues it downstream and reloads that counter. Optional macro VPU_ISSUE_STALL_CNT_EN adds stall_cnt_o.
`timescale 1ns/1ps

module vpu_cmd_issue_gate #(
  parameter int unsigned CNTR_WIDTH = 4,
  parameter int unsigned NUM_CNTR   = 4,
  parameter int unsigned CMD_WIDTH  = 8,
  parameter int unsigned SEL_WIDTH  = (NUM_CNTR > 1) ? $clog2(NUM_CNTR) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [CMD_WIDTH-1:0]           cmd_i,
  input  logic [SEL_WIDTH-1:0]           cmd_sel_i,
  input  logic [CNTR_WIDTH-1:0]          cmd_delay_i,
  output logic                           issue_valid_o,
  input  logic                           issue_ready_i,
  output logic [CMD_WIDTH-1:0]           issue_cmd_o,
  output logic [NUM_CNTR-1:0]            cntr_reset_cmd_o,
  output logic [NUM_CNTR*CNTR_WIDTH-1:0] cntr_reset_value_o,
  input  logic [NUM_CNTR-1:0]            cntr_is_zero_i
`ifdef VPU_ISSUE_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    accept;
  logic                    guard_zero;
  logic [CMD_WIDTH-1:0]    cmd_q;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic [CNTR_WIDTH-1:0]   delay_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cmd_q   <= '0;
      sel_q   <= '0;
      delay_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q   <= cmd_i;
        sel_q   <= cmd_sel_i;
        delay_q <= cmd_delay_i;
      end
    end
  end

  // A select with no matching lane (sel >= NUM_CNTR) is unguarded: it reads as zero.
  always_comb begin
    guard_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_CNTR; i++) begin
      if (sel_q == SEL_WIDTH'(i)) guard_zero = cntr_is_zero_i[i];
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (guard_zero) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (issue_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready_o   = (state == S_IDLE);
  assign issue_valid_o = (state == S_ISSUE);
  assign issue_cmd_o   = cmd_q;

  // Reload lane is driven only while issuing; the strobe additionally needs the handshake.
  always_comb begin
    cntr_reset_cmd_o   = '0;
    cntr_reset_value_o = '0;
    for (int unsigned i = 0; i < NUM_CNTR; i++) begin
      if ((state == S_ISSUE) && (sel_q == SEL_WIDTH'(i))) begin
        cntr_reset_cmd_o[i]                          = issue_ready_i;
        cntr_reset_value_o[i*CNTR_WIDTH +: CNTR_WIDTH] = delay_q;
      end
    end
  end

`ifdef VPU_ISSUE_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if ((state == S_WAIT) && !guard_zero && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vpu_cmd_issue_gate.sv
// Self-checking bench for vpu_cmd_issue_gate: vector table plus reset, real-counter and unguarded-select sequences.
`timescale 1ns/1ps

module tb_vpu_cmd_issue_gate;

  localparam int W = 4;
  localparam int N = 4;
  localparam int C = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_ready;
  logic [C-1:0]   cmd_in;
  logic [1:0]     cmd_sel;
  logic [W-1:0]   cmd_delay;
  logic           issue_valid, issue_ready;
  logic [C-1:0]   issue_cmd;
  logic [N-1:0]   strobe;
  logic [N*W-1:0] rvalue;
  logic [N-1:0]   is_zero;
  logic [N-1:0]   zero_manual;
  logic           use_real;
  logic [W-1:0]   cnt0;
`ifdef VPU_ISSUE_STALL_CNT_EN
  logic [15:0]    stall_cnt, d3_stall_cnt;
  int             exp_stall;
`endif

  // second instance with a non-power-of-two counter count
  logic           d3_cmd_valid, d3_cmd_ready, d3_issue_valid, d3_issue_ready;
  logic [C-1:0]   d3_cmd_in, d3_issue_cmd;
  logic [1:0]     d3_sel;
  logic [W-1:0]   d3_delay;
  logic [2:0]     d3_strobe, d3_zero;
  logic [3*W-1:0] d3_rvalue;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [3:0]  mask;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [7:0]  cmd;
    logic [1:0]  sel;
    logic [3:0]  dly;
    int          stall;
    int          rlow;
    int          lat;
    logic [3:0]  mask;
    logic [15:0] val;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  vpu_cmd_issue_gate #(.CNTR_WIDTH(W), .NUM_CNTR(N), .CMD_WIDTH(C)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_i(cmd_in),
    .cmd_sel_i(cmd_sel), .cmd_delay_i(cmd_delay),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready), .issue_cmd_o(issue_cmd),
    .cntr_reset_cmd_o(strobe), .cntr_reset_value_o(rvalue), .cntr_is_zero_i(is_zero)
`ifdef VPU_ISSUE_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  vpu_cmd_issue_gate #(.CNTR_WIDTH(W), .NUM_CNTR(3), .CMD_WIDTH(C), .SEL_WIDTH(2)) u_dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid_i(d3_cmd_valid), .cmd_ready_o(d3_cmd_ready), .cmd_i(d3_cmd_in),
    .cmd_sel_i(d3_sel), .cmd_delay_i(d3_delay),
    .issue_valid_o(d3_issue_valid), .issue_ready_i(d3_issue_ready), .issue_cmd_o(d3_issue_cmd),
    .cntr_reset_cmd_o(d3_strobe), .cntr_reset_value_o(d3_rvalue), .cntr_is_zero_i(d3_zero)
`ifdef VPU_ISSUE_STALL_CNT_EN
    , .stall_cnt_o(d3_stall_cnt)
`endif
  );

  // timing counter model on lane 0: loads on strobe, counts down, zero flag from the register
  always @(posedge clk or posedge rst) begin
    if (rst) cnt0 <= '0;
    else if (strobe[0]) cnt0 <= rvalue[W-1:0];
    else if (cnt0 != 0) cnt0 <= cnt0 - 4'd1;
  end
  assign is_zero = use_real ? {zero_manual[3:1], (cnt0 == 4'd0)} : zero_manual;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // handshake monitor: pops the scoreboard on every issue, otherwise no strobe may appear
  always @(negedge clk) begin
    if (!rst) begin
      if (issue_valid && issue_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("issue_cmd", {24'd0, issue_cmd}, {24'd0, mon_e.cmd});
          check("strobe_mask", {28'd0, strobe}, {28'd0, mon_e.mask});
          check("strobe_value", {16'd0, rvalue}, {16'd0, mon_e.val});
        end
      end else begin
        check("no_strobe", {28'd0, strobe}, 32'd0);
      end
      if (!issue_valid) check("value_idle", {16'd0, rvalue}, 32'd0);
    end
  end

  // called in an IDLE cycle #1 after the edge; returns cycles from accept to issue_valid
  task automatic send_cmd(input logic [7:0] cmd, input logic [1:0] sel, input logic [3:0] dly,
                          input int stall, input int rlow, input logic [3:0] mask,
                          input logic [15:0] val, output int lat);
    exp_t e;
    int   c;
    check("ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid   = 1'b1;
    cmd_in      = cmd;
    cmd_sel     = sel;
    cmd_delay   = dly;
    issue_ready = (rlow == 0);
    if (stall >= 0) zero_manual = (stall == 0) ? (4'b0001 << sel) : 4'b0000;
    e.cmd = cmd; e.mask = mask; e.val = val;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_in    = 8'($urandom);
    cmd_sel   = 2'($urandom);
    cmd_delay = 4'($urandom);
    c   = 1;
    lat = -1;
    while (lat < 0 && c < stall + 60) begin
      if (stall >= 0) zero_manual = (c > stall) ? (4'b0001 << sel) : 4'b0000;
      @(negedge clk);
      if (issue_valid) begin
        lat = c;
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (lat < 0) begin
      check("issue_timeout", 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < rlow; k++) begin
      check("hold_cmd", {24'd0, issue_cmd}, {24'd0, cmd});
      check("hold_valid", {31'd0, issue_valid}, 32'd1);
      check("hold_ready_o", {31'd0, cmd_ready}, 32'd0);
      check("hold_value", {16'd0, rvalue}, {16'd0, val});
      @(posedge clk); #1;
      if (k == rlow - 1) issue_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    issue_ready = 1'b0;
    check("post_valid", {31'd0, issue_valid}, 32'd0);
    check("post_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_valid"}, {31'd0, issue_valid}, 32'd0);
    check({tag, "_cmd"}, {24'd0, issue_cmd}, 32'd0);
    check({tag, "_strobe"}, {28'd0, strobe}, 32'd0);
    check({tag, "_value"}, {16'd0, rvalue}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_a, lat_b;

    vecs[0] = '{8'hA5, 2'd2, 4'h5, 0, 0, 2, 4'b0100, 16'h0500};
    vecs[1] = '{8'h3C, 2'd1, 4'h9, 7, 0, 9, 4'b0010, 16'h0090};
    vecs[2] = '{8'h5A, 2'd3, 4'hF, 2, 4, 4, 4'b1000, 16'hF000};
    vecs[3] = '{8'h81, 2'd0, 4'h0, 1, 1, 3, 4'b0001, 16'h0000};
    vecs[4] = '{8'hFF, 2'd2, 4'hA, 0, 2, 2, 4'b0100, 16'h0A00};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_in = '0; cmd_sel = '0; cmd_delay = '0;
    issue_ready = 1'b0; zero_manual = '1; use_real = 1'b0;
    d3_cmd_valid = 1'b0; d3_cmd_in = '0; d3_sel = '0; d3_delay = '0;
    d3_issue_ready = 1'b0; d3_zero = '0;
`ifdef VPU_ISSUE_STALL_CNT_EN
    exp_stall = 0;
`endif
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send_cmd(vecs[i].cmd, vecs[i].sel, vecs[i].dly, vecs[i].stall, vecs[i].rlow,
               vecs[i].mask, vecs[i].val, lat);
      check($sformatf("latency_v%0d", i), lat, vecs[i].lat);
`ifdef VPU_ISSUE_STALL_CNT_EN
      exp_stall += vecs[i].stall;
      check($sformatf("stall_cnt_v%0d", i), {16'd0, stall_cnt}, exp_stall);
`endif
    end

    // lane 0 driven by the counter model: delay 3, then delay 0, then an unstalled follow-up
    use_real = 1'b1;
    send_cmd(8'h11, 2'd0, 4'h3, -1, 0, 4'b0001, 16'h0003, lat);
    check("real_first_lat", lat, 2);
    send_cmd(8'h22, 2'd0, 4'h0, -1, 0, 4'b0001, 16'h0000, lat_a);
    check("real_second_lat", lat_a, 4);
    send_cmd(8'h33, 2'd0, 4'h7, -1, 0, 4'b0001, 16'h0007, lat_b);
    check("real_after_zero_delay_lat", lat_b, 2);
    use_real = 1'b0;
`ifdef VPU_ISSUE_STALL_CNT_EN
    exp_stall += 2;
    check("stall_cnt_real", {16'd0, stall_cnt}, exp_stall);
`endif

    // reset while in WAIT: command is dropped
    cmd_valid = 1'b1; cmd_in = 8'hC3; cmd_sel = 2'd1; cmd_delay = 4'h4; zero_manual = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("wait_ready_low", {31'd0, cmd_ready}, 32'd0);
    #2; rst = 1'b1; #1;
    check_reset_outputs("rst_wait");
    zero_manual = '1;
    @(negedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dropped_no_issue", {31'd0, issue_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // reset while in ISSUE with downstream ready raised in the same instant
    cmd_valid = 1'b1; cmd_in = 8'h6E; cmd_sel = 2'd2; cmd_delay = 4'h6; zero_manual = '1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("issue_before_rst", {31'd0, issue_valid}, 32'd1);
    check("issue_value_before_rst", {16'd0, rvalue}, 32'h0600);
    issue_ready = 1'b1; rst = 1'b1; #1;
    check_reset_outputs("rst_issue");
    issue_ready = 1'b0;
    @(negedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
`ifdef VPU_ISSUE_STALL_CNT_EN
    exp_stall = 0;
    check("stall_cnt_after_rst", {16'd0, stall_cnt}, 32'd0);
`endif
    send_cmd(8'h77, 2'd2, 4'h3, 0, 0, 4'b0100, 16'h0300, lat);
    check("first_after_rst_lat", lat, 2);

    // unguarded select on the three-counter instance
    d3_cmd_valid = 1'b1; d3_cmd_in = 8'h9D; d3_sel = 2'd3; d3_delay = 4'h8;
    d3_zero = 3'b000; d3_issue_ready = 1'b1;
    @(posedge clk); #1;
    d3_cmd_valid = 1'b0;
    @(negedge clk);
    check("d3_wait_valid", {31'd0, d3_issue_valid}, 32'd0);
    @(negedge clk);
    check("d3_issue_valid", {31'd0, d3_issue_valid}, 32'd1);
    check("d3_issue_cmd", {24'd0, d3_issue_cmd}, 32'h9D);
    check("d3_no_strobe", {29'd0, d3_strobe}, 32'd0);
    check("d3_no_value", {20'd0, d3_rvalue}, 32'd0);
    @(posedge clk); #1;
    d3_issue_ready = 1'b0;
    check("d3_back_idle", {31'd0, d3_cmd_ready}, 32'd1);
`ifdef VPU_ISSUE_STALL_CNT_EN
    check("d3_stall_cnt", {16'd0, d3_stall_cnt}, 32'd0);

    // long stall to reach saturation
    send_cmd(8'hE1, 2'd1, 4'h2, 65600, 0, 4'b0010, 16'h0020, lat);
    check("sat_lat", lat, 65602);
    check("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
